// File: rtl/lr_alu_seq.sv
// ---------------------------------------------------------------------------
// lr_alu_seq
//
// Sequential LR35902-style ALU that owns the architectural flag register
// {Z,N,H,C}. One operation is accepted at a time over a valid/ready
// handshake. The operation then executes for one or more cycles and the
// result is held until the consumer takes it.
//
// Parameters
//   WIDTH  single-operand width (multiple of 4, >= 8); double ops use 2*WIDTH
//   SHW    width of the shift step-count input
//
// Ports
//   i_clk        clock, all state changes on the rising edge
//   i_rst_n      synchronous active-low reset
//   i_in_valid   operation offered
//   o_in_ready   block can accept (IDLE only)
//   i_op         5-bit opcode
//   i_a, i_b     2*WIDTH operands
//   i_cnt        shift step count minus one
//   i_flags_we   write the flag register when the operation completes
//   i_flags_ld   direct flag load, honoured in IDLE only
//   i_flags_in   {Z,N,H,C} value for i_flags_ld
//   o_out_valid  result available
//   i_out_ready  consumer takes the result
//   o_d          registered result, stable while o_out_valid
//   o_flags      flag register {Z,N,H,C}
// ---------------------------------------------------------------------------
module lr_alu_seq #(
    parameter int WIDTH = 8,
    parameter int SHW   = 3
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_in_valid,
    output logic                 o_in_ready,
    input  logic [4:0]           i_op,
    input  logic [2*WIDTH-1:0]   i_a,
    input  logic [2*WIDTH-1:0]   i_b,
    input  logic [SHW-1:0]       i_cnt,
    input  logic                 i_flags_we,
    input  logic                 i_flags_ld,
    input  logic [3:0]           i_flags_in,
    output logic                 o_out_valid,
    input  logic                 i_out_ready,
    output logic [2*WIDTH-1:0]   o_d,
    output logic [3:0]           o_flags
);

    localparam int DW = 2 * WIDTH;

    localparam logic [4:0] OP_OR   = 5'h00;
    localparam logic [4:0] OP_AND  = 5'h01;
    localparam logic [4:0] OP_XOR  = 5'h02;
    localparam logic [4:0] OP_CPL  = 5'h03;
    localparam logic [4:0] OP_ADD2 = 5'h04;
    localparam logic [4:0] OP_ADD  = 5'h05;
    localparam logic [4:0] OP_ADC  = 5'h06;
    localparam logic [4:0] OP_SUB  = 5'h07;
    localparam logic [4:0] OP_SBC  = 5'h08;
    localparam logic [4:0] OP_RLC  = 5'h09;
    localparam logic [4:0] OP_RL   = 5'h0A;
    localparam logic [4:0] OP_RRC  = 5'h0B;
    localparam logic [4:0] OP_RR   = 5'h0C;
    localparam logic [4:0] OP_SLA  = 5'h0D;
    localparam logic [4:0] OP_SRA  = 5'h0E;
    localparam logic [4:0] OP_SRL  = 5'h0F;
    localparam logic [4:0] OP_SWAP = 5'h10;
    localparam logic [4:0] OP_DAA  = 5'h11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               w_accept;
    logic               w_finish;

    logic [4:0]         r_op;
    logic [DW-1:0]      r_a;
    logic [DW-1:0]      r_b;
    logic               r_we;
    logic               r_carry;     // working carry, updated per shift step
    logic [WIDTH-1:0]   r_work;      // iterated value for shifts / DAA
    logic [SHW-1:0]     r_step;      // remaining EXEC cycles minus one
    logic [DW-1:0]      r_d;
    logic [3:0]         r_flags;

    logic [SHW-1:0]     w_step_init;
    logic [WIDTH-1:0]   w_a_lo, w_a_hi, w_b_lo;
    logic               w_cin;
    logic [WIDTH:0]     w_add, w_sub;
    logic [DW:0]        w_add2;
    logic [WIDTH-1:0]   w_logic;
    logic [WIDTH-1:0]   w_sh_res;
    logic               w_sh_out;
    logic [WIDTH-1:0]   w_daa_lo, w_daa_hi, w_swap;
    logic               w_daa_c;
    logic [DW-1:0]      w_res_d;
    logic [3:0]         w_res_flags;
    logic               w_res_wr;
    logic [WIDTH-1:0]   w_work_next;
    logic               w_carry_next;

    // -----------------------------------------------------------------------
    // FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        o_in_ready   = 1'b0;
        o_out_valid  = 1'b0;
        w_accept     = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_in_ready = 1'b1;
                if (i_in_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                if (r_step == '0) begin
                    w_finish     = 1'b1;
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                o_out_valid = 1'b1;
                if (i_out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Shifts run cnt+1 steps, DAA two steps, everything else one.
    always_comb begin
        w_step_init = '0;
        if (i_op >= OP_RLC && i_op <= OP_SRL) begin
            w_step_init = i_cnt;
        end else if (i_op == OP_DAA) begin
            w_step_init = SHW'(1);
        end
    end

    // -----------------------------------------------------------------------
    // Datapath
    // -----------------------------------------------------------------------
    assign w_a_lo = r_a[WIDTH-1:0];
    assign w_a_hi = r_a[DW-1:WIDTH];
    assign w_b_lo = r_b[WIDTH-1:0];
    assign w_cin  = (r_op == OP_ADC || r_op == OP_SBC) ? r_carry : 1'b0;

    // The bit-3 half carry/borrow is recovered as sum^a^b at bit 4.
    assign w_add  = {1'b0, w_a_lo} + {1'b0, w_b_lo} + {{WIDTH{1'b0}}, w_cin};
    assign w_sub  = {1'b0, w_a_lo} - {1'b0, w_b_lo} - {{WIDTH{1'b0}}, w_cin};
    assign w_add2 = {1'b0, r_a} + {1'b0, r_b};

    always_comb begin
        w_logic = w_a_lo | w_b_lo;
        if (r_op == OP_AND) begin
            w_logic = w_a_lo & w_b_lo;
        end else if (r_op == OP_XOR) begin
            w_logic = w_a_lo ^ w_b_lo;
        end
    end

    // One step of the shift/rotate family on the working value.
    always_comb begin
        w_sh_res = r_work;
        w_sh_out = 1'b0;
        case (r_op)
            OP_RLC: begin
                w_sh_out = r_work[WIDTH-1];
                w_sh_res = {r_work[WIDTH-2:0], r_work[WIDTH-1]};
            end
            OP_RL: begin
                w_sh_out = r_work[WIDTH-1];
                w_sh_res = {r_work[WIDTH-2:0], r_carry};
            end
            OP_RRC: begin
                w_sh_out = r_work[0];
                w_sh_res = {r_work[0], r_work[WIDTH-1:1]};
            end
            OP_RR: begin
                w_sh_out = r_work[0];
                w_sh_res = {r_carry, r_work[WIDTH-1:1]};
            end
            OP_SLA: begin
                w_sh_out = r_work[WIDTH-1];
                w_sh_res = {r_work[WIDTH-2:0], 1'b0};
            end
            OP_SRA: begin
                w_sh_out = r_work[0];
                w_sh_res = {r_work[WIDTH-1], r_work[WIDTH-1:1]};
            end
            OP_SRL: begin
                w_sh_out = r_work[0];
                w_sh_res = {1'b0, r_work[WIDTH-1:1]};
            end
            default: begin
                w_sh_res = r_work;
                w_sh_out = 1'b0;
            end
        endcase
    end

    // SWAP and DAA only touch bits 7:0; anything above passes through.
    always_comb begin
        w_swap      = w_a_lo;
        w_swap[7:0] = {w_a_lo[3:0], w_a_lo[7:4]};

        w_daa_lo = r_work;
        if (!r_flags[2] && (r_flags[1] || r_work[3:0] > 4'd9)) begin
            w_daa_lo[7:0] = r_work[7:0] + 8'h06;
        end else if (r_flags[2] && r_flags[1]) begin
            w_daa_lo[7:0] = r_work[7:0] - 8'h06;
        end

        // High-digit decision looks at the operand as it was accepted.
        w_daa_hi = r_work;
        w_daa_c  = r_carry;
        if (!r_flags[2] && (r_carry || w_a_lo[7:0] > 8'h99)) begin
            w_daa_hi[7:0] = r_work[7:0] + 8'h60;
            w_daa_c       = 1'b1;
        end else if (r_flags[2] && r_carry) begin
            w_daa_hi[7:0] = r_work[7:0] - 8'h60;
        end
    end

    // Result, flag image and per-step state for the current EXEC cycle.
    always_comb begin
        w_res_d      = '0;
        w_res_flags  = r_flags;
        w_res_wr     = 1'b0;
        w_work_next  = r_work;
        w_carry_next = r_carry;
        case (r_op)
            OP_OR, OP_AND, OP_XOR: begin
                w_res_d     = {w_a_hi, w_logic};
                w_res_flags = {(w_logic == '0), 1'b0, (r_op == OP_AND), 1'b0};
                w_res_wr    = 1'b1;
            end
            OP_CPL: begin
                w_res_d     = {w_a_hi, ~w_a_lo};
                w_res_flags = {r_flags[3], 1'b1, 1'b1, r_flags[0]};
                w_res_wr    = 1'b1;
            end
            OP_ADD, OP_ADC: begin
                w_res_d     = {{WIDTH{1'b0}}, w_add[WIDTH-1:0]};
                w_res_flags = {(w_add[WIDTH-1:0] == '0), 1'b0,
                               w_add[4] ^ w_a_lo[4] ^ w_b_lo[4], w_add[WIDTH]};
                w_res_wr    = 1'b1;
            end
            OP_SUB, OP_SBC: begin
                w_res_d     = {{WIDTH{1'b0}}, w_sub[WIDTH-1:0]};
                w_res_flags = {(w_sub[WIDTH-1:0] == '0), 1'b1,
                               w_sub[4] ^ w_a_lo[4] ^ w_b_lo[4], w_sub[WIDTH]};
                w_res_wr    = 1'b1;
            end
            OP_ADD2: begin
                w_res_d     = w_add2[DW-1:0];
                w_res_flags = {r_flags[3], 1'b0,
                               w_add2[DW-4] ^ r_a[DW-4] ^ r_b[DW-4], w_add2[DW]};
                w_res_wr    = 1'b1;
            end
            OP_RLC, OP_RL, OP_RRC, OP_RR, OP_SLA, OP_SRA, OP_SRL: begin
                w_work_next  = w_sh_res;
                w_carry_next = w_sh_out;
                w_res_d      = {{WIDTH{1'b0}}, w_sh_res};
                w_res_flags  = {(w_sh_res == '0), 1'b0, 1'b0, w_sh_out};
                w_res_wr     = 1'b1;
            end
            OP_SWAP: begin
                w_res_d     = {{WIDTH{1'b0}}, w_swap};
                w_res_flags = {(w_swap == '0), 1'b0, 1'b0, 1'b0};
                w_res_wr    = 1'b1;
            end
            OP_DAA: begin
                w_work_next = w_daa_lo;
                w_res_d     = {{WIDTH{1'b0}}, w_daa_hi};
                w_res_flags = {(w_daa_hi == '0), r_flags[2], 1'b0, w_daa_c};
                w_res_wr    = 1'b1;
            end
            default: begin
                w_res_d  = '0;
                w_res_wr = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_we    <= 1'b0;
            r_carry <= 1'b0;
            r_work  <= '0;
            r_step  <= '0;
            r_d     <= '0;
            r_flags <= '0;
        end else begin
            if (r_state == S_IDLE && i_flags_ld) begin
                r_flags <= i_flags_in;
            end
            if (w_accept) begin
                r_op    <= i_op;
                r_a     <= i_a;
                r_b     <= i_b;
                r_we    <= i_flags_we;
                r_carry <= i_flags_ld ? i_flags_in[0] : r_flags[0];
                r_work  <= i_a[WIDTH-1:0];
                r_step  <= w_step_init;
            end
            if (r_state == S_EXEC) begin
                r_work  <= w_work_next;
                r_carry <= w_carry_next;
                if (r_step != '0) begin
                    r_step <= r_step - SHW'(1);
                end
            end
            if (w_finish) begin
                r_d <= w_res_d;
                if (r_we && w_res_wr) begin
                    r_flags <= w_res_flags;
                end
            end
        end
    end

    assign o_d     = r_d;
    assign o_flags = r_flags;

endmodule
